// File: rtl/id_stage_if.sv
// Decode-stage bundle: IF/ID, WB and EX inputs plus every decoded output.
// The slave side is the decode stage itself; the master side feeds it.
interface id_stage_if;
  logic [31:0] PC_ID;
  logic [31:0] INSTR_ID;
  logic        RegWrite_WB;
  logic [4:0]  rd_WB;
  logic [31:0] DATA_WB;
  logic        MemRead_EX;
  logic [4:0]  rd_EX;

  logic [31:0] PC_ID_out;
  logic [31:0] RS1_DATA;
  logic [31:0] RS2_DATA;
  logic [31:0] IMM_ID;
  logic [4:0]  RS1_ID;
  logic [4:0]  RS2_ID;
  logic [4:0]  RD_ID;
  logic [2:0]  FUNCT3_ID;
  logic [6:0]  FUNCT7_ID;
  logic [6:0]  OPCODE_ID;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        ALUSrc;
  logic        Branch;
  logic [1:0]  ALUOp;
  logic        PC_write;
  logic        IF_ID_write;
  logic        control_sel;

  modport master (
    output PC_ID, INSTR_ID, RegWrite_WB, rd_WB, DATA_WB, MemRead_EX, rd_EX,
    input  PC_ID_out, RS1_DATA, RS2_DATA, IMM_ID, RS1_ID, RS2_ID, RD_ID, FUNCT3_ID,
           FUNCT7_ID, OPCODE_ID, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch,
           ALUOp, PC_write, IF_ID_write, control_sel
  );

  modport slave (
    input  PC_ID, INSTR_ID, RegWrite_WB, rd_WB, DATA_WB, MemRead_EX, rd_EX,
    output PC_ID_out, RS1_DATA, RS2_DATA, IMM_ID, RS1_ID, RS2_ID, RD_ID, FUNCT3_ID,
           FUNCT7_ID, OPCODE_ID, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch,
           ALUOp, PC_write, IF_ID_write, control_sel
  );
endinterface

// File: rtl/id_stage.sv
// RISC-V instruction decode: register file with write-first bypass, immediate
// generation, main control word and load-use hazard detection.
module id_stage #(
  parameter int unsigned REG_COUNT = 32
) (
  input logic       clk,
  input logic       reset,
  id_stage_if.slave bus
);
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  logic [31:0] regs_q [REG_COUNT];
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2;
  logic        wb_we;
  logic        rs1_used, rs2_used, stall;
  logic [7:0]  ctrl;

  assign instr  = bus.INSTR_ID;
  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign wb_we  = bus.RegWrite_WB && (bus.rd_WB != 5'd0);

  // A WB write on an edge where reset is high is lost: reset has priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[bus.rd_WB] <= bus.DATA_WB;
    end
  end

  always_comb begin
    bus.RS1_DATA = regs_q[rs1];
    if (rs1 == 5'd0)                        bus.RS1_DATA = '0;
    else if (wb_we && (bus.rd_WB == rs1))   bus.RS1_DATA = bus.DATA_WB;
    bus.RS2_DATA = regs_q[rs2];
    if (rs2 == 5'd0)                        bus.RS2_DATA = '0;
    else if (wb_we && (bus.rd_WB == rs2))   bus.RS2_DATA = bus.DATA_WB;
  end

  always_comb begin
    bus.IMM_ID = '0;
    unique case (opcode)
      OpImm, OpLoad, OpJalr: bus.IMM_ID = {{20{instr[31]}}, instr[31:20]};
      OpStore:  bus.IMM_ID = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OpBranch: bus.IMM_ID = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OpLui, OpAuipc: bus.IMM_ID = {instr[31:12], 12'b0};
      OpJal: bus.IMM_ID = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: bus.IMM_ID = '0;
    endcase
  end

  // ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp}
  always_comb begin
    ctrl = 8'b0;
    unique case (opcode)
      OpReg:    ctrl = 8'b1000_0010;
      OpImm:    ctrl = 8'b1000_1011;
      OpLoad:   ctrl = 8'b1101_1000;
      OpStore:  ctrl = 8'b0010_1000;
      OpBranch: ctrl = 8'b0000_0101;
      default:  ctrl = 8'b0;
    endcase
  end

  always_comb begin
    rs1_used = !((opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal));
    rs2_used = (opcode == OpReg) || (opcode == OpStore) || (opcode == OpBranch);
    stall    = bus.MemRead_EX && (bus.rd_EX != 5'd0) &&
               ((rs1_used && (bus.rd_EX == rs1)) || (rs2_used && (bus.rd_EX == rs2)));
  end

  assign {bus.RegWrite, bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.ALUSrc, bus.Branch,
          bus.ALUOp} = stall ? 8'b0 : ctrl;
  assign bus.PC_write    = !stall;
  assign bus.IF_ID_write = !stall;
  assign bus.control_sel = stall;

  assign bus.PC_ID_out = bus.PC_ID;
  assign bus.RS1_ID    = rs1;
  assign bus.RS2_ID    = rs2;
  assign bus.RD_ID     = instr[11:7];
  assign bus.FUNCT3_ID = instr[14:12];
  assign bus.FUNCT7_ID = instr[31:25];
  assign bus.OPCODE_ID = opcode;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: expectations are queued as stimulus is applied and
// checked against the decoded outputs once they have settled.
module tb_id_stage;
  localparam int SelRs1 = 0, SelRs2 = 1, SelImm = 2, SelCtrl = 3, SelHaz = 4,
                 SelPc = 5, SelFields = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  id_stage_if bus_if ();

  id_stage #(.REG_COUNT(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelRs1:  return bus_if.RS1_DATA;
      SelRs2:  return bus_if.RS2_DATA;
      SelImm:  return bus_if.IMM_ID;
      SelCtrl: return {24'd0, bus_if.RegWrite, bus_if.MemRead, bus_if.MemWrite,
                       bus_if.MemtoReg, bus_if.ALUSrc, bus_if.Branch, bus_if.ALUOp};
      SelHaz:  return {29'd0, bus_if.PC_write, bus_if.IF_ID_write, bus_if.control_sel};
      SelPc:   return bus_if.PC_ID_out;
      default: return {bus_if.FUNCT7_ID, bus_if.FUNCT3_ID, bus_if.OPCODE_ID,
                       bus_if.RS1_ID, bus_if.RS2_ID, bus_if.RD_ID};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    bus_if.RegWrite_WB = we;
    bus_if.rd_WB       = rd;
    bus_if.DATA_WB     = data;
  endtask

  task automatic ex(input logic mr, input logic [4:0] rd);
    bus_if.MemRead_EX = mr;
    bus_if.rd_EX      = rd;
  endtask

  // Advance one full cycle so any pending WB write commits, then idle WB.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    wb(1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus_if.PC_ID    = 32'd0;
    bus_if.INSTR_ID = 32'd0;
    wb(1'b0, 5'd0, 32'd0);
    ex(1'b0, 5'd0);
    @(negedge clk);
    expect_out("haz_in_reset", SelHaz, 32'h6);
    drain();
    // Write attempted while reset is held must be dropped.
    wb(1'b1, 5'd3, 32'h77);
    tick();
    reset = 1'b0;
    @(negedge clk);

    for (int i = 1; i < 32; i++) begin
      bus_if.INSTR_ID = {7'd0, 5'(i), 5'(i), 3'd0, 5'd1, 7'h33};
      expect_out($sformatf("rst_rs1_x%0d", i), SelRs1, 32'h0);
      expect_out($sformatf("rst_rs2_x%0d", i), SelRs2, 32'h0);
      drain();
    end

    wb(1'b1, 5'd5, 32'h0000_1234);
    tick();
    bus_if.PC_ID    = 32'h8000_0010;
    bus_if.INSTR_ID = 32'h0072_8333;
    expect_out("add_rs1", SelRs1, 32'h0000_1234);
    expect_out("add_rs2", SelRs2, 32'h0);
    expect_out("add_ctrl", SelCtrl, 32'h82);
    expect_out("add_haz", SelHaz, 32'h6);
    expect_out("add_imm", SelImm, 32'h0);
    expect_out("add_pc", SelPc, 32'h8000_0010);
    expect_out("add_fields", SelFields, {7'd0, 3'd0, 7'h33, 5'd5, 5'd7, 5'd6});
    drain();

    wb(1'b1, 5'd0, 32'hDEAD_BEEF);
    bus_if.INSTR_ID = 32'h0000_0033;
    expect_out("x0_nobypass", SelRs1, 32'h0);
    drain();
    tick();
    expect_out("x0_read", SelRs1, 32'h0);
    drain();

    wb(1'b1, 5'd7, 32'hCAFE_F00D);
    bus_if.INSTR_ID = 32'h0072_8333;
    expect_out("bypass_rs2", SelRs2, 32'hCAFE_F00D);
    expect_out("bypass_rs1", SelRs1, 32'h0000_1234);
    drain();
    tick();
    expect_out("stored_rs2", SelRs2, 32'hCAFE_F00D);
    drain();

    // Load-use stall with a concurrent WB write that must still commit.
    ex(1'b1, 5'd5);
    wb(1'b1, 5'd8, 32'h88);
    expect_out("stall_haz", SelHaz, 32'h1);
    expect_out("stall_ctrl", SelCtrl, 32'h0);
    drain();
    tick();
    ex(1'b1, 5'd0);
    expect_out("rdex0_haz", SelHaz, 32'h6);
    expect_out("rdex0_ctrl", SelCtrl, 32'h82);
    drain();
    ex(1'b0, 5'd0);
    bus_if.INSTR_ID = 32'h0004_0333;
    expect_out("stall_wb_commit", SelRs1, 32'h88);
    drain();

    ex(1'b1, 5'd5);
    bus_if.INSTR_ID = 32'h0050_0093;
    expect_out("addi_rs2unused_haz", SelHaz, 32'h6);
    expect_out("addi_ctrl", SelCtrl, 32'h8B);
    expect_out("addi_imm", SelImm, 32'h5);
    drain();

    ex(1'b1, 5'd8);
    bus_if.INSTR_ID = 32'h1234_52B7;
    expect_out("lui_haz", SelHaz, 32'h6);
    expect_out("lui_imm", SelImm, 32'h1234_5000);
    expect_out("lui_ctrl", SelCtrl, 32'h0);
    drain();

    ex(1'b1, 5'd7);
    bus_if.INSTR_ID = 32'hFE72_AE23;
    expect_out("sw_stall_haz", SelHaz, 32'h1);
    expect_out("sw_stall_ctrl", SelCtrl, 32'h0);
    expect_out("sw_imm", SelImm, 32'hFFFF_FFFC);
    drain();
    ex(1'b0, 5'd0);
    expect_out("sw_ctrl", SelCtrl, 32'h28);
    drain();

    bus_if.INSTR_ID = 32'hFE00_0EE3;
    expect_out("beq_imm", SelImm, 32'hFFFF_FFFC);
    expect_out("beq_ctrl", SelCtrl, 32'h05);
    drain();
    bus_if.INSTR_ID = 32'h0082_A083;
    expect_out("lw_imm", SelImm, 32'h8);
    expect_out("lw_ctrl", SelCtrl, 32'hD8);
    drain();
    bus_if.INSTR_ID = 32'hFF9F_F06F;
    expect_out("jal_imm", SelImm, 32'hFFFF_FFF8);
    expect_out("jal_ctrl", SelCtrl, 32'h0);
    drain();
    bus_if.INSTR_ID = 32'hFFC2_8067;
    expect_out("jalr_imm", SelImm, 32'hFFFF_FFFC);
    drain();
    bus_if.INSTR_ID = 32'hFFF0_0073;
    expect_out("sys_imm", SelImm, 32'h0);
    expect_out("sys_ctrl", SelCtrl, 32'h0);
    drain();

    wb(1'b1, 5'd9, 32'h55);
    tick();
    bus_if.INSTR_ID = 32'h0004_8093;
    expect_out("x9_written", SelRs1, 32'h55);
    drain();
    #1;
    reset = 1'b1;
    expect_out("x9_async_clear", SelRs1, 32'h0);
    expect_out("haz_reset_mid", SelHaz, 32'h6);
    drain();
    @(negedge clk);
    reset = 1'b0;
    bus_if.INSTR_ID = 32'h0001_8093;
    expect_out("x3_reset_write_dropped", SelRs1, 32'h0);
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
